// File: rtl/linear_1d_pkg.sv
// Shared types and AXI constants for the 1-D linear core result writer.
// Holds the writer FSM encoding and AXI beat-size helpers.
package linear_1d_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_FIN
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int PAGE_BYTES = 4096;

  function automatic int bytes_per_beat(input int width);
    return width / 8;
  endfunction

  function automatic logic [2:0] axsize(input int width);
    return 3'($clog2(width / 8));
  endfunction

endpackage

// File: rtl/linear_1d_wr_burst_len.sv
// Burst length chooser for the result writer.
// Picks min(remaining, MAX_BURST, beats left in the current 4KB page).
module linear_1d_wr_burst_len
  import linear_1d_pkg::*;
#(
  parameter int AXI_WIDTH_DA = 32,
  parameter int MAX_BURST    = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic [11:0]          addr_lo,
  input  logic [CNT_WIDTH-1:0] remain,
  output logic [8:0]           len
);

  localparam int SZ = int'(axsize(AXI_WIDTH_DA));

  logic [12:0] room_bytes;
  logic [12:0] room_beats;
  logic [31:0] cap;
  logic [31:0] pick;

  // Page room, then clamp by burst limit and remaining results.
  always_comb begin
    room_bytes = 13'(PAGE_BYTES) - {1'b0, addr_lo};
    room_beats = room_bytes >> SZ;
    cap = (32'(room_beats) < 32'(MAX_BURST)) ?
          32'(room_beats) : 32'(MAX_BURST);
    pick = (32'(remain) < cap) ? 32'(remain) : cap;
    len = 9'(pick);
  end

endmodule

// File: rtl/linear_1d_result_writer.sv
// Result stream to AXI4 INCR write bursts for the 1-D linear core.
// One burst outstanding at a time; W path is a pass-through of the result FIFO.
module linear_1d_result_writer
  import linear_1d_pkg::*;
#(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_ID       = 1,
  parameter int MAX_BURST    = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      go,
  input  logic [AXI_WIDTH_AD-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]      num_results,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  input  logic [AXI_WIDTH_DA-1:0]   res_data,
  input  logic                      res_valid,
  output logic                      res_ready,
  output logic [AXI_WIDTH_ID-1:0]   M_AWID,
  output logic [AXI_WIDTH_AD-1:0]   M_AWADDR,
  output logic [7:0]                M_AWLEN,
  output logic [2:0]                M_AWSIZE,
  output logic [1:0]                M_AWBURST,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [AXI_WIDTH_DA-1:0]   M_WDATA,
  output logic [AXI_WIDTH_DA/8-1:0] M_WSTRB,
  output logic                      M_WLAST,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [AXI_WIDTH_ID-1:0]   M_BID,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY
);

  localparam int SZ = int'(axsize(AXI_WIDTH_DA));

  state_t state, state_nx;

  logic [AXI_WIDTH_AD-1:0] addr;
  logic [CNT_WIDTH-1:0]    remain;
  logic [8:0]              beat_cnt;
  logic [8:0]              len_q;
  logic [8:0]              len;
  logic                    w_fire;
  logic                    last_beat;
  logic                    bid_unused;

  assign bid_unused = ^M_BID;

  linear_1d_wr_burst_len #(
    .AXI_WIDTH_DA (AXI_WIDTH_DA),
    .MAX_BURST    (MAX_BURST),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_len (
    .addr_lo (addr[11:0]),
    .remain  (remain),
    .len     (len)
  );

  assign M_AWID    = AXI_WIDTH_ID'(AXI_ID);
  assign M_AWSIZE  = axsize(AXI_WIDTH_DA);
  assign M_AWBURST = BURST_INCR;
  assign M_WSTRB   = '1;

  assign M_AWVALID = (state == ST_ADDR);
  assign M_AWADDR  = addr;
  assign M_AWLEN   = M_AWVALID ? 8'(len - 9'd1) : 8'd0;

  assign M_WVALID  = (state == ST_DATA) && res_valid;
  assign res_ready = (state == ST_DATA) && M_WREADY;
  assign M_WDATA   = res_data;
  assign last_beat = (beat_cnt == 9'd1);
  assign M_WLAST   = (state == ST_DATA) && last_beat;
  assign w_fire    = M_WVALID && M_WREADY;

  assign M_BREADY  = (state == ST_RESP);
  assign busy      = (state == ST_ADDR) || (state == ST_DATA) ||
                     (state == ST_RESP);
  assign done      = (state == ST_FIN);

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (go)
          state_nx = (num_results == '0) ? ST_FIN : ST_ADDR;
      ST_ADDR:
        if (M_AWREADY) state_nx = ST_DATA;
      ST_DATA:
        if (w_fire && last_beat) state_nx = ST_RESP;
      ST_RESP:
        if (M_BVALID)
          state_nx = (remain == '0) ? ST_FIN : ST_ADDR;
      ST_FIN:
        state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  // Address, counters and sticky error.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr     <= '0;
      remain   <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      error    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE:
          if (go) begin
            addr   <= base_addr;
            remain <= num_results;
            error  <= 1'b0;
          end
        ST_ADDR:
          if (M_AWREADY) begin
            beat_cnt <= len;
            len_q    <= len;
          end
        ST_DATA:
          if (w_fire) begin
            beat_cnt <= beat_cnt - 9'd1;
            remain   <= remain - 1'b1;
          end
        ST_RESP:
          if (M_BVALID) begin
            if (M_BRESP != RESP_OKAY) error <= 1'b1;
            addr <= addr + (AXI_WIDTH_AD'(len_q) << SZ);
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_1d_result_writer.sv
// Scoreboard bench for linear_1d_result_writer.
// Stimulus pushes expected AW/W traffic; a monitor pops and compares.
module tb_linear_1d_result_writer;

  logic        clk = 1'b0;
  logic        ARESET;
  logic        go;
  logic [31:0] base_addr;
  logic [15:0] num_results;
  logic        busy, done, error;
  logic [31:0] res_data;
  logic        res_valid, res_ready;
  logic [3:0]  M_AWID;
  logic [31:0] M_AWADDR;
  logic [7:0]  M_AWLEN;
  logic [2:0]  M_AWSIZE;
  logic [1:0]  M_AWBURST;
  logic        M_AWVALID, M_AWREADY;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        M_WLAST, M_WVALID, M_WREADY;
  logic [3:0]  M_BID;
  logic [1:0]  M_BRESP;
  logic        M_BVALID, M_BREADY;

  always #5 clk = ~clk;

  linear_1d_result_writer dut (
    .ACLK(clk), .ARESET(ARESET), .go(go),
    .base_addr(base_addr), .num_results(num_results),
    .busy(busy), .done(done), .error(error),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN),
    .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID),
    .M_BREADY(M_BREADY)
  );

  int checks = 0;
  int failures = 0;

  logic [39:0] aw_exp[$];
  logic [32:0] w_exp[$];
  logic [31:0] src_q[$];
  int          lens[$];

  int stall_pct = 0;
  int err_burst = -1;
  int burst_no = 0;
  int aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=missing expected=present", name);
  endtask

  // Slave and result source: inputs change 1 time unit after posedge.
  bit f_w, f_last, f_b;
  initial begin
    res_valid = 0; res_data = 0;
    M_AWREADY = 0; M_WREADY = 0;
    M_BVALID = 0; M_BRESP = 0; M_BID = 4'd1;
    forever begin
      @(negedge clk);
      f_w = M_WVALID && M_WREADY;
      f_last = f_w && M_WLAST;
      f_b = M_BVALID && M_BREADY;
      @(posedge clk);
      #1;
      if (ARESET) begin
        src_q.delete();
        res_valid = 0;
        M_BVALID = 0;
        M_BRESP = 0;
      end else begin
        if (f_w && src_q.size() > 0) void'(src_q.pop_front());
        if (f_b) begin
          M_BVALID = 0;
          burst_no++;
        end
        if (f_last) begin
          M_BVALID = 1;
          M_BRESP = (burst_no == err_burst) ? 2'b10 : 2'b00;
        end
        if (!res_valid || f_w) begin
          res_valid = (src_q.size() > 0) &&
                      (stall_pct == 0 || $urandom_range(99) >= stall_pct);
          res_data = (src_q.size() > 0) ? src_q[0] : 32'h0;
        end
      end
      M_AWREADY = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      M_WREADY  = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
    end
  end

  // Monitor: scoreboard pops and stall-stability checks.
  bit          aw_wait, w_wait;
  logic [39:0] aw_hold;
  logic [32:0] w_hold;
  initial begin
    aw_wait = 0;
    w_wait = 0;
    forever begin
      @(negedge clk);
      if (ARESET) begin
        aw_wait = 0;
        w_wait = 0;
      end else begin
        if (aw_wait)
          check("aw_stable", {M_AWVALID, M_AWADDR, M_AWLEN},
                {1'b1, aw_hold});
        if (w_wait)
          check("w_stable", {M_WVALID, M_WDATA, M_WLAST}, {1'b1, w_hold});
        if (M_AWVALID && M_AWREADY) begin
          aw_cnt++;
          if (aw_exp.size() == 0) fail_now("aw_unexpected");
          else check("aw", {M_AWADDR, M_AWLEN}, aw_exp.pop_front());
          check("aw_attr", {M_AWID, M_AWSIZE, M_AWBURST, M_WSTRB},
                {4'd1, 3'd2, 2'b01, 4'hF});
        end
        if (M_WVALID && M_WREADY) begin
          w_cnt++;
          if (M_WLAST) wlast_cnt++;
          if (w_exp.size() == 0) fail_now("w_unexpected");
          else check("w", {M_WDATA, M_WLAST}, w_exp.pop_front());
        end
        aw_wait = M_AWVALID && !M_AWREADY;
        aw_hold = {M_AWADDR, M_AWLEN};
        w_wait = M_WVALID && !M_WREADY;
        w_hold = {M_WDATA, M_WLAST};
        if (done) done_cnt++;
      end
    end
  end

  // Queue expected traffic for the bursts in lens, then pulse go.
  task automatic launch(input logic [31:0] base, input int num,
                        input logic [31:0] dbase);
    logic [31:0] a;
    int k;
    a = base;
    k = 0;
    burst_no = 0;
    foreach (lens[b]) begin
      aw_exp.push_back({a, 8'(lens[b] - 1)});
      for (int j = 0; j < lens[b]; j++) begin
        w_exp.push_back({dbase + 32'(k), j == lens[b] - 1});
        src_q.push_back(dbase + 32'(k));
        k++;
      end
      a += 32'(lens[b] * 4);
    end
    @(posedge clk);
    #1;
    base_addr = base;
    num_results = 16'(num);
    go = 1;
    @(posedge clk);
    #1;
    go = 0;
  endtask

  task automatic plan(input logic [31:0] base, input int num);
    int rem, room, l;
    logic [31:0] a;
    lens = {};
    rem = num;
    a = base;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      l = rem;
      if (l > 16) l = 16;
      if (l > room) l = room;
      lens.push_back(l);
      rem -= l;
      a += 32'(l * 4);
    end
  endtask

  task automatic wait_done(input string name);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      fail_now({name, "_timeout"});
    end else begin
      repeat (3) @(negedge clk);
      check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
      check({name, "_drained"}, 64'(aw_exp.size() + w_exp.size()), 64'd0);
      check({name, "_busy_low"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ctl"},
          {busy, done, error, res_ready, M_AWVALID, M_WVALID, M_WLAST,
           M_BREADY}, 8'h00);
    check({name, "_aw"}, {M_AWADDR, M_AWLEN}, 40'h0);
  endtask

  initial begin
    int d0, a0, wl0, n;
    ARESET = 1;
    go = 0;
    base_addr = 0;
    num_results = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    ARESET = 0;

    // Three bursts 16/16/8 from 0x1000, results 0..39.
    lens = {16, 16, 8};
    launch(32'h1000, 40, 32'h0);
    @(negedge clk);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1");

    // 4KB split: 0x0FF8 gives 2 beats, then 2 beats at 0x1000.
    lens = {2, 2};
    launch(32'h0FF8, 4, 32'hB000_0000);
    wait_done("t2");

    // Zero results: done right after go, no bus activity.
    lens = {};
    d0 = done_cnt;
    a0 = aw_cnt;
    launch(32'h3000, 0, 32'h0);
    @(negedge clk);
    check("t3_done", {done, busy}, 2'b10);
    repeat (3) @(negedge clk);
    check("t3_done_once", 64'(done_cnt - d0), 64'd1);
    check("t3_no_aw", 64'(aw_cnt - a0), 64'd0);

    // Random stalls over 100 results crossing a page boundary.
    stall_pct = 30;
    plan(32'h2F40, 100);
    a0 = aw_cnt;
    wl0 = wlast_cnt;
    launch(32'h2F40, 100, 32'hC000_0000);
    wait_done("t4");
    check("t4_bursts", 64'(aw_cnt - a0), 64'(lens.size()));
    check("t4_wlast", 64'(wlast_cnt - wl0), 64'(lens.size()));
    stall_pct = 0;

    // SLVERR on second of three bursts.
    err_burst = 1;
    lens = {16, 16, 8};
    launch(32'h4000, 40, 32'hD000_0000);
    wait_done("t5");
    check("t5_error", 64'(error), 64'd1);
    err_burst = -1;
    lens = {1};
    launch(32'h5000, 1, 32'hE000_0000);
    @(negedge clk);
    check("t5_error_cleared", 64'(error), 64'd0);
    wait_done("t5b");

    // Reset in the middle of the data phase.
    lens = {16, 16, 8};
    a0 = w_cnt;
    launch(32'h6000, 40, 32'hF000_0000);
    n = 0;
    while (w_cnt < a0 + 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (w_cnt < a0 + 5) fail_now("t6_reach_data");
    @(posedge clk);
    #1;
    ARESET = 1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("t6_reset");
    aw_exp.delete();
    w_exp.delete();
    @(posedge clk);
    #1;
    ARESET = 0;
    lens = {8};
    launch(32'h7000, 8, 32'h1234_0000);
    wait_done("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
